seg7_bcd_counter_mux: RTL and testbench

//  Parametrised N-digit BCD up/down counter driving a multiplexed 7-segment display.

---
 rtl/seg7_bcd_counter_mux.sv | 239 +++++++++++++++++++++++
 tb/tb_seg7_bcd_counter_mux.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_counter_mux.sv
// -----------------------------------------------------------------------------
// seg7_bcd_counter_mux
//
// Purpose:
//   N-digit BCD up/down counter with a prescaled count tick, driving a
//   multiplexed 7-segment display. Each digit is held for MUX_DIV clocks
//   before the scan moves to the next one. Segment, decimal point and digit
//   enable outputs are registered. When SEG_ACTIVE_LOW is non-zero they are
//   inverted in that register, which suits common-anode displays.
//
// Optional build feature:
//   SEG7_LZB_EN  Defining this macro enables leading-zero blanking. A digit
//                i>0 goes dark when it and every higher digit are zero.
//                Digit 0 is never blanked. The decimal point still follows
//                i_dp_mask.
//
// Parameters:
//   DIGITS          number of BCD digits (>=1); digit 0 is least significant
//   PRESCALE        clocks per count tick (>=1)
//   MUX_DIV         clocks each digit is held during the scan (>=1)
//   SEG_ACTIVE_LOW  1: o_seg/o_dp/o_dig_sel are inverted at the output register
//
// Ports:
//   i_clk        clock; all logic on the rising edge
//   i_rst_n      synchronous reset, active low
//   i_en         1: prescaler runs; 0: prescaler and count frozen (scan keeps going)
//   i_up         count direction, sampled on tick (1 = up)
//   i_load       load i_load_val this cycle (nibbles above 9 load as 9)
//   i_load_val   BCD nibbles; nibble i goes to digit i
//   i_dp_mask    decimal point lit while digit i is scanned if bit i is set
//   o_seg        registered segments, bit0 = A .. bit6 = G
//   o_dp         registered decimal point
//   o_dig_sel    registered one-hot digit enable
//   o_value      current count (direct view of the count register)
//   o_carry      one-cycle pulse after a wrap (up 9..9 -> 0, down 0 -> 9..9)
// -----------------------------------------------------------------------------
module seg7_bcd_counter_mux #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int MUX_DIV        = 16,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    input  logic [DIGITS-1:0]     i_dp_mask,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_dig_sel,
    output logic [4*DIGITS-1:0]   o_value,
    output logic                  o_carry
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MUX_W = (MUX_DIV > 1)  ? $clog2(MUX_DIV)  : 1;
    localparam int IDX_W = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [MUX_W-1:0] MUX_LAST = MUX_W'(MUX_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic             INV      = (SEG_ACTIVE_LOW != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_cnt;
    logic [PRE_W-1:0]    r_pre_rem;     // clocks left until the next tick
    logic [MUX_W-1:0]    r_mux_rem;     // clocks left on the current digit
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig_sel;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                w_tick;
    logic [4*DIGITS-1:0] w_load_val;
    logic [4*DIGITS-1:0] w_cnt_step;
    logic                w_ripple;
    logic                w_wrap;
    logic [3:0]          w_dig;
    logic [3:0]          w_sel_dig;
    logic                w_dp_raw;
    logic [DIGITS-1:0]   w_dsel_raw;
    logic                w_blank;
    logic [6:0]          w_seg_raw;
`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0]   w_lz;          // bit i: digit i and all higher digits are zero
    logic                w_hi_zero;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // A tick is the last clock of a prescale period while enabled.
    assign w_tick = i_en && (r_pre_rem == '0);

    // Out-of-range load nibbles saturate to 9 so the count stays valid BCD.
    always_comb begin
        w_load_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_val[4*i +: 4] = (i_load_val[4*i +: 4] > 4'd9) ? 4'd9 : i_load_val[4*i +: 4];
        end
    end

    // One-cycle ripple: a digit moves only while every lower digit sits at its
    // terminal value (9 going up, 0 going down). Ripple surviving past the top
    // digit means the whole counter wrapped.
    always_comb begin
        w_cnt_step = r_cnt;
        w_ripple   = 1'b1;
        w_dig      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = r_cnt[4*i +: 4];
            if (w_ripple) begin
                if (i_up) begin
                    w_cnt_step[4*i +: 4] = (w_dig >= 4'd9) ? 4'd0 : w_dig + 4'd1;
                end else begin
                    w_cnt_step[4*i +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
                end
            end
            w_ripple = w_ripple & (i_up ? (w_dig >= 4'd9) : (w_dig == 4'd0));
        end
        w_wrap = w_ripple;
    end

`ifdef SEG7_LZB_EN
    always_comb begin
        w_lz      = '0;
        w_hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_hi_zero = w_hi_zero & (r_cnt[4*i +: 4] == 4'd0);
            w_lz[i]   = w_hi_zero;
        end
    end
`endif

    // Digit selection for the scan. A compare loop is used in place of a
    // variable part-select so that DIGITS=1 needs no special case.
    always_comb begin
        w_sel_dig  = 4'd0;
        w_dp_raw   = 1'b0;
        w_dsel_raw = '0;
        w_blank    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_dig     = r_cnt[4*i +: 4];
                w_dp_raw      = i_dp_mask[i];
                w_dsel_raw[i] = 1'b1;
`ifdef SEG7_LZB_EN
                w_blank       = (i > 0) && w_lz[i];
`endif
            end
        end
        w_seg_raw = w_blank ? 7'h00 : glyph(w_sel_dig);
    end

    // ------------------------------------------------------------------
    // Count and prescaler. The order of priority is reset, then load, then tick.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_pre_rem <= PRE_LAST;
            r_carry   <= 1'b0;
        end else if (i_load) begin
            r_cnt     <= w_load_val;
            r_pre_rem <= PRE_LAST;
            r_carry   <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (w_tick) begin
                r_cnt     <= w_cnt_step;
                r_carry   <= w_wrap;
                r_pre_rem <= PRE_LAST;
            end else if (i_en) begin
                r_pre_rem <= r_pre_rem - PRE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan timer. It runs freely after reset and ignores i_en.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mux_rem <= MUX_LAST;
            r_idx     <= '0;
        end else if (r_mux_rem == '0) begin
            r_mux_rem <= MUX_LAST;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_mux_rem <= r_mux_rem - MUX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Display output register. Polarity inversion happens here, so reset
    // drives the dark level of whichever polarity is built.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_seg     <= {7{INV}};
            r_dp      <= INV;
            r_dig_sel <= {DIGITS{INV}};
        end else begin
            r_seg     <= w_seg_raw ^ {7{INV}};
            r_dp      <= w_dp_raw ^ INV;
            r_dig_sel <= w_dsel_raw ^ {DIGITS{INV}};
        end
    end

    assign o_seg     = r_seg;
    assign o_dp      = r_dp;
    assign o_dig_sel = r_dig_sel;
    assign o_value   = r_cnt;
    assign o_carry   = r_carry;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
module tb_seg7_bcd_counter_mux;

    localparam int DIG = 4;
    localparam int PRE = 4;
    localparam int MUX = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [3:0]  dp_mask;

    logic [6:0]  seg,      seg_al;
    logic        dp,       dp_al;
    logic [3:0]  dsel,     dsel_al;
    logic [15:0] value,    value_al;
    logic        carry,    carry_al;

    int total = 0;
    int bad   = 0;
    string phase = "init";

    typedef struct packed {
        logic [6:0]  seg;
        logic        dp;
        logic [3:0]  dsel;
        logic [15:0] value;
        logic        carry;
    } exp_t;

    exp_t sb_q[$];

    // reference model state: the count is kept as a plain decimal integer
    int   m_val, m_pre, m_mux, m_idx;
    logic m_carry;

    seg7_bcd_counter_mux #(.DIGITS(DIG), .PRESCALE(PRE), .MUX_DIV(MUX), .SEG_ACTIVE_LOW(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(load_val), .i_dp_mask(dp_mask),
        .o_seg(seg), .o_dp(dp), .o_dig_sel(dsel), .o_value(value), .o_carry(carry)
    );

    seg7_bcd_counter_mux #(.DIGITS(DIG), .PRESCALE(PRE), .MUX_DIV(MUX), .SEG_ACTIVE_LOW(1)) u_dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(load_val), .i_dp_mask(dp_mask),
        .o_seg(seg_al), .o_dp(dp_al), .o_dig_sel(dsel_al), .o_value(value_al), .o_carry(carry_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd_to_int(input logic [15:0] b);
        int r = 0;
        int d;
        for (int k = 0; k < DIG; k++) begin
            d = int'(b[4*k +: 4]);
            if (d > 9) d = 9;
            r = r + d * pow10(k);
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < DIG; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int idx);
`ifdef SEG7_LZB_EN
        if (idx > 0 && v < pow10(idx)) return 7'h00;
`endif
        return ref_glyph((v / pow10(idx)) % 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, act, exp);
        end
    endtask

    // Advance the model over one clock, push the expectation, clock the DUTs,
    // then pop and compare.
    task automatic step();
        exp_t e;
        exp_t x;
        logic [6:0] inv_seg;
        logic [3:0] inv_dsel;
        logic       inv_dp;
        e = '0;
        if (!rst_n) begin
            m_val = 0; m_pre = 0; m_mux = 0; m_idx = 0; m_carry = 1'b0;
        end else begin
            e.dsel = 4'(1 << m_idx);
            e.seg  = model_seg(m_val, m_idx);
            e.dp   = dp_mask[m_idx];
            if (m_mux == MUX - 1) begin
                m_mux = 0;
                m_idx = (m_idx == DIG - 1) ? 0 : m_idx + 1;
            end else begin
                m_mux++;
            end
            m_carry = 1'b0;
            if (load) begin
                m_val = bcd_to_int(load_val);
                m_pre = 0;
            end else if (en) begin
                if (m_pre == PRE - 1) begin
                    m_pre = 0;
                    if (up) begin
                        if (m_val == 9999) begin m_val = 0; m_carry = 1'b1; end
                        else m_val++;
                    end else begin
                        if (m_val == 0) begin m_val = 9999; m_carry = 1'b1; end
                        else m_val--;
                    end
                end else begin
                    m_pre++;
                end
            end
        end
        e.value = int_to_bcd(m_val);
        e.carry = m_carry;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        inv_seg  = ~x.seg;
        inv_dsel = ~x.dsel;
        inv_dp   = ~x.dp;
        check("seg",      32'(seg),      32'(x.seg));
        check("dp",       32'(dp),       32'(x.dp));
        check("dig_sel",  32'(dsel),     32'(x.dsel));
        check("value",    32'(value),    32'(x.value));
        check("carry",    32'(carry),    32'(x.carry));
        check("seg_al",   32'(seg_al),   32'(inv_seg));
        check("dp_al",    32'(dp_al),    32'(inv_dp));
        check("dsel_al",  32'(dsel_al),  32'(inv_dsel));
        check("value_al", 32'(value_al), 32'(x.value));
        check("carry_al", 32'(carry_al), 32'(x.carry));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1;
        load_val = 16'h1234; dp_mask = 4'b0000;
        m_val = 0; m_pre = 0; m_mux = 0; m_idx = 0; m_carry = 1'b0;

        // reset held with LOAD and EN active
        phase = "reset";
        steps(3);
        check("rst_value",  32'(value),    32'h0000);
        check("rst_seg",    32'(seg),      32'h00);
        check("rst_dsel",   32'(dsel),     32'h0);
        check("rst_carry",  32'(carry),    32'h0);
        check("rst_seg_al", 32'(seg_al),   32'h7F);

        // scan of an all-zero count
        phase = "scan";
        rst_n = 1'b1; load = 1'b0; en = 1'b0;
        step(); check("scan0", 32'(dsel), 32'h1);
        step(); check("scan1", 32'(dsel), 32'h1);
        step(); check("scan2", 32'(dsel), 32'h2);
        steps(2); check("scan4", 32'(dsel), 32'h4);
        steps(2); check("scan6", 32'(dsel), 32'h8);
        steps(2); check("scan8", 32'(dsel), 32'h1);

        // count up from zero for 40 clocks
        phase = "count_up";
        en = 1'b1; up = 1'b1;
        steps(40);
        check("after40", 32'(value), 32'h0010);

        // up wrap from 9999
        phase = "wrap_up";
        load = 1'b1; load_val = 16'h9999;
        step();
        load = 1'b0;
        steps(3);
        check("pre_wrap_v", 32'(value), 32'h9999);
        check("pre_wrap_c", 32'(carry), 32'h0);
        step();
        check("wrap_v", 32'(value), 32'h0000);
        check("wrap_c", 32'(carry), 32'h1);
        step();
        check("post_wrap_c", 32'(carry), 32'h0);
        steps(3);

        // down wrap from 0000
        phase = "wrap_down";
        load = 1'b1; load_val = 16'h0000; up = 1'b0;
        step();
        load = 1'b0;
        steps(3);
        step();
        check("dwrap_v", 32'(value), 32'h9999);
        check("dwrap_c", 32'(carry), 32'h1);
        steps(5);

        // saturating load of an out-of-range nibble
        phase = "load_clamp";
        load = 1'b1; load_val = 16'h12F4; en = 1'b0;
        step();
        load = 1'b0;
        check("clamp", 32'(value), 32'h1294);
        steps(4);

        // load on the tick cycle: load wins and the prescaler restarts
        phase = "load_on_tick";
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < PRE && m_pre != PRE - 1; k++) step();
        load = 1'b1; load_val = 16'h0500;
        step();
        load = 1'b0;
        check("lot_v", 32'(value), 32'h0500);
        check("lot_c", 32'(carry), 32'h0);
        steps(3);
        check("lot_hold", 32'(value), 32'h0500);
        step();
        check("lot_tick", 32'(value), 32'h0501);

        // blanking view of 0070 with DP on digit 0
        phase = "lzb";
        en = 1'b0; load = 1'b1; load_val = 16'h0070; dp_mask = 4'b0001;
        step();
        load = 1'b0;
        steps(10);

        // digit 8 then reset partway through a scan
        phase = "active_low";
        load = 1'b1; load_val = 16'h0008; dp_mask = 4'b0000;
        step();
        load = 1'b0;
        steps(7);
        rst_n = 1'b0;
        step();
        check("al_rst_seg",  32'(seg_al),  32'h7F);
        check("al_rst_dsel", 32'(dsel_al), 32'hF);
        rst_n = 1'b1;
        steps(3);

        // random mix of enable, direction, loads and occasional reset
        phase = "random";
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 19) == 0);
            load_val = 16'($urandom);
            dp_mask  = 4'($urandom);
            rst_n    = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1; load = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
